// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment driver for a signed XX.X value.
// New values are staged in a pending register and only go live on a frame boundary.
module display_scan #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       neg,
    input  logic [3:0] int_hi,
    input  logic [3:0] int_lo,
    input  logic [3:0] frac,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [PW-1:0] cnt;
    logic [1:0]    slot;
    logic          tick;
    logic          wrap;

    logic       pend_flag;
    logic       pend_neg;
    logic [3:0] pend_hi, pend_lo, pend_frac;
    logic       act_neg;
    logic [3:0] act_hi, act_lo, act_frac;

    logic [3:0] nxt_an;
    logic [6:0] nxt_seg;
    logic       nxt_dp;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0000110;
        endcase
    endfunction

    assign tick = (cnt == LAST);
    assign wrap = tick && (slot == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            slot  <= 2'd0;
            frame <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            slot  <= tick ? slot + 2'd1 : slot;
            frame <= wrap;
        end
    end

    // A load landing on the wrap tick bypasses pending so it is not lost for a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_flag <= 1'b0;
            pend_neg  <= 1'b0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_frac <= '0;
            act_neg   <= 1'b0;
            act_hi    <= '0;
            act_lo    <= '0;
            act_frac  <= '0;
        end else if (load && wrap) begin
            act_neg   <= neg;
            act_hi    <= int_hi;
            act_lo    <= int_lo;
            act_frac  <= frac;
            pend_flag <= 1'b0;
        end else begin
            if (wrap && pend_flag) begin
                act_neg  <= pend_neg;
                act_hi   <= pend_hi;
                act_lo   <= pend_lo;
                act_frac <= pend_frac;
            end
            if (load) begin
                pend_neg  <= neg;
                pend_hi   <= int_hi;
                pend_lo   <= int_lo;
                pend_frac <= frac;
                pend_flag <= 1'b1;
            end else if (wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        nxt_an  = ~(4'b0001 << slot);
        nxt_seg = SEG_BLANK;
        nxt_dp  = 1'b1;
        case (slot)
            2'd0: nxt_seg = decode(act_frac);
            2'd1: begin
                nxt_seg = decode(act_lo);
                nxt_dp  = 1'b0;
            end
            2'd2: nxt_seg = (act_hi == 4'd0) ? SEG_BLANK : decode(act_hi);
            default: nxt_seg = act_neg ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= nxt_an;
            seg <= nxt_seg;
            dp  <= nxt_dp;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with DIV=4: directed scenarios plus random loads,
// checked against a time-based model of which load is visible in which frame.
module tb_display_scan;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       neg = 1'b0;
    logic [3:0] int_hi = '0, int_lo = '0, frac = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame;

    int checks = 0;
    int errors = 0;
    int ecount = 0;   // rising edges since reset release

    typedef struct {
        int         e;
        logic       n;
        logic [3:0] h, l, f;
    } ld_t;
    ld_t q[$];

    logic [6:0] dec_tab [16];

    display_scan #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .neg(neg),
        .int_hi(int_hi), .int_lo(int_lo), .frac(frac),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: got %b expected %b", tag, ecount, got, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: got %b expected %b", tag, ecount, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: got %b expected %b", tag, ecount, got, exp);
        end
    endtask

    // Outputs after edge e show the digit selected during cycle e-1, using the
    // last load sampled at or before the most recent frame boundary.
    task automatic check();
        int   s, b;
        ld_t  act;
        logic [6:0] es;
        logic       ed;
        if (!rst_n) begin
            chk4("rst_an", an, 4'b1111);
            chk7("rst_seg", seg, 7'b1111111);
            chk1("rst_dp", dp, 1'b1);
            chk1("rst_frame", frame, 1'b0);
            return;
        end
        s   = ((ecount - 1) / DIV) % 4;
        b   = ((ecount - 1) / FRAME) * FRAME;
        act = '{0, 1'b0, 4'd0, 4'd0, 4'd0};
        foreach (q[i]) if (q[i].e <= b) act = q[i];
        ed = 1'b1;
        case (s)
            0: es = dec_tab[act.f];
            1: begin es = dec_tab[act.l]; ed = 1'b0; end
            2: es = (act.h == 4'd0) ? 7'b1111111 : dec_tab[act.h];
            default: es = act.n ? 7'b0111111 : 7'b1111111;
        endcase
        chk4("an", an, 4'b1111 & ~(4'b0001 << s));
        chk7("seg", seg, es);
        chk1("dp", dp, ed);
        chk1("frame", frame, (ecount % FRAME) == 0);
    endtask

    task automatic cyc(input logic ld, input logic n, input logic [3:0] h, input logic [3:0] l,
                       input logic [3:0] f);
        load = ld; neg = n; int_hi = h; int_lo = l; frac = f;
        @(posedge clk);
        if (rst_n) begin
            ecount++;
            if (ld) q.push_back('{ecount, n, h, l, f});
        end
        #1 load = 1'b0;
        @(negedge clk);
        check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    // Advance until the next edge sampled will be edge number with ecount+1 == r (mod FRAME).
    task automatic align(input int r);
        for (int i = 0; i < FRAME && ((ecount + 1) % FRAME) != r; i++) idle(1);
    endtask

    initial begin
        dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110,
                    7'b0000110};

        // Reset state, then idle scan of zeros
        repeat (2) begin @(negedge clk); check(); end
        rst_n = 1'b1;
        idle(32);

        // Mid-frame load shows only from the next frame
        align(6);
        cyc(1'b1, 1'b1, 4'd0, 4'd3, 4'd5);
        idle(36);

        // Two loads in one frame: last one wins
        align(3);
        cyc(1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
        idle(4);
        cyc(1'b1, 1'b0, 4'd4, 4'd5, 4'd6);
        idle(34);

        // Load on the wrap tick goes straight to the display
        align(0);
        cyc(1'b1, 1'b0, 4'd2, 4'd7, 4'd9);
        idle(34);

        // Out-of-range digits show E, including the tens digit
        align(9);
        cyc(1'b1, 1'b0, 4'd10, 4'd1, 4'd12);
        idle(34);

        // Random loads, including ones that land on wrap ticks
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0)
                cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            else
                idle(1);
        end

        // Reset during slot 2 with a load still pending
        align(1);
        cyc(1'b1, 1'b1, 4'd8, 4'd8, 4'd8);
        while (((ecount / DIV) % 4) != 2) idle(1);
        #2 rst_n = 1'b0;
        #1 check();
        q.delete();
        ecount = 0;
        repeat (2) begin @(negedge clk); check(); end
        rst_n = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
